// File: rtl/filter_collector.sv
`default_nettype none
// ============================================================================
// Module   : filter_collector
// Brief    : Downstream collector for the Filter/FilterBlock chain. Buffers
//            the chain's y-stream (data + parity) in a small circular FIFO and
//            re-presents it with a valid/ready handshake. Beats that arrive
//            while the FIFO is full (and not draining) are dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module filter_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        io_x_data,
    input  logic                         io_x_valid,
    input  logic                         io_x_parity,
    output logic [DATA_WIDTH-1:0]        io_y_data,
    output logic                         io_y_parity,
    output logic                         io_y_valid,
    input  logic                         io_y_ready,
    output logic [$clog2(DEPTH):0]       io_count,
    output logic                         io_overflow,
    output logic [DROP_WIDTH-1:0]        io_drop_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + 1;

    localparam logic [CNT_W-1:0]      C_FULL      = CNT_W'(DEPTH);
    localparam logic [DROP_WIDTH-1:0] C_DROP_MAX  = {DROP_WIDTH{1'b1}};

    // Storage array; never reset, contents are only meaningful below count.
    logic [ENTRY_W-1:0]    mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    logic                  pop_w;
    logic                  push_w;
    logic                  drop_w;
    logic                  full_w;

    // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
    // that is draining still accepts the incoming beat.
    always_comb begin
        full_w = (count_q == C_FULL);
        pop_w  = (count_q != '0) && io_y_ready;
        push_w = io_x_valid && (!full_w || pop_w);
        drop_w = io_x_valid && full_w && !pop_w;
    end

    // Next-state for pointers, occupancy and drop bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        // DEPTH is a power of two, so natural pointer rollover is the wrap.
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push_w && !pop_w) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_w && !push_w) begin
            count_d = count_q - CNT_W'(1);
        end

        if (drop_w) begin
            overflow_d = 1'b1;
            if (drop_q != C_DROP_MAX) begin
                drop_d = drop_q + DROP_WIDTH'(1);
            end
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Entry write; beats presented while in reset are ignored.
    always_ff @(posedge clk) begin
        if (reset && push_w) begin
            mem_q[wr_ptr_q] <= {io_x_parity, io_x_data};
        end
    end

    // First-word-fall-through read of the head entry.
    assign io_y_data     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign io_y_parity   = mem_q[rd_ptr_q][DATA_WIDTH];
    assign io_y_valid    = (count_q != '0);
    assign io_count      = count_q;
    assign io_overflow   = overflow_q;
    assign io_drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_collector
// Brief    : Scoreboard bench for filter_collector. The stimulus process keeps
//            an occupancy/drop model and queues every accepted beat; a monitor
//            compares the DUT head and status outputs on each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_collector;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int DROPW = 8;
    localparam int DROP_MAX = (1 << DROPW) - 1;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   x_data;
    logic            x_valid;
    logic            x_parity;
    logic [DW-1:0]   y_data;
    logic            y_parity;
    logic            y_valid;
    logic            y_ready;
    logic [2:0]      count;
    logic            overflow;
    logic [DROPW-1:0] drop_count;

    int checks;
    int errors;

    // Reference state: accepted beats in order, plus status counters.
    logic [DW:0] exp_q [$];
    int          mdl_count;
    bit          mdl_ovf;
    int          mdl_drop;
    bit          mon_en;

    filter_collector #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .DROP_WIDTH (DROPW)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .io_x_data     (x_data),
        .io_x_valid    (x_valid),
        .io_x_parity   (x_parity),
        .io_y_data     (y_data),
        .io_y_parity   (y_parity),
        .io_y_valid    (y_valid),
        .io_y_ready    (y_ready),
        .io_count      (count),
        .io_overflow   (overflow),
        .io_drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and advance the reference at the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic p,
                        input logic rdy, input logic rstn);
        bit pop;
        bit push;
        reset    = rstn;
        x_valid  = v;
        x_data   = d;
        x_parity = p;
        y_ready  = rdy;
        pop  = (mdl_count != 0) && rdy;
        push = v && ((mdl_count < DEPTH) || pop);
        @(posedge clk);
        if (!rstn) begin
            exp_q.delete();
            mdl_count = 0;
            mdl_ovf   = 0;
            mdl_drop  = 0;
        end else begin
            if (push) exp_q.push_back({p, d});
            if (push && !pop) mdl_count = mdl_count + 1;
            if (pop && !push) mdl_count = mdl_count - 1;
            if (v && !push) begin
                mdl_ovf  = 1;
                if (mdl_drop < DROP_MAX) mdl_drop = mdl_drop + 1;
            end
        end
        #1;
    endtask

    // Monitor: status and head comparisons away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks = checks + 4;
            if (count !== 3'(mdl_count)) begin
                errors = errors + 1;
                $display("FAIL count: got %0d want %0d @%0t", count, mdl_count, $time);
            end
            if (y_valid !== (mdl_count != 0)) begin
                errors = errors + 1;
                $display("FAIL y_valid: got %b want %b @%0t", y_valid, (mdl_count != 0), $time);
            end
            if (overflow !== mdl_ovf) begin
                errors = errors + 1;
                $display("FAIL overflow: got %b want %b @%0t", overflow, mdl_ovf, $time);
            end
            if (drop_count !== DROPW'(mdl_drop)) begin
                errors = errors + 1;
                $display("FAIL drop_count: got %0d want %0d @%0t", drop_count, mdl_drop, $time);
            end
            if (y_valid === 1'b1) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL head: got %b_%h want nothing queued @%0t", y_parity, y_data, $time);
                end else begin
                    if ({y_parity, y_data} !== exp_q[0]) begin
                        errors = errors + 1;
                        $display("FAIL head: got %b_%h want %b_%h @%0t",
                                 y_parity, y_data, exp_q[0][DW], exp_q[0][DW-1:0], $time);
                    end
                    if (y_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mon_en  = 0;
        mdl_count = 0;
        mdl_ovf   = 0;
        mdl_drop  = 0;
        reset   = 1'b0;
        x_valid = 1'b0;
        x_data  = '0;
        x_parity = 1'b0;
        y_ready = 1'b0;

        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mon_en = 1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Single beat through an empty FIFO.
        step(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Fill, overflow with 0x0005, then drain.
        for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'(i), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset clears the sticky flag, then full + simultaneous push/pop.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, DW'(16'hA0 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h00A4, 1'b1, 1'b1, 1'b1);
        drain();

        // Continuous streaming, one beat per cycle.
        for (int i = 0; i < 20; i++) step(1'b1, DW'(i), 1'(i), 1'b1, 1'b1);
        drain();

        // Drop-counter saturation.
        for (int i = 0; i < 300; i++) step(1'b1, DW'(16'h8000 + i), 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Mid-stream reset with overflow set and a beat presented.
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h0C00 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), DW'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 4), !($urandom_range(0, 99) == 0));
        end
        drain();

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL residue: got %0d beats left want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
